// File: rtl/br_flow_mux_lru_pkt_if.sv
// Bundle of the handshake and data signals around the packet-aware LRU flow
// mux: N push ports on the upstream side and a single pop port downstream.
//
// Signals:
//   push_valid [N]    upstream valid, one bit per requester
//   push_ready [N]    upstream ready, one bit per requester
//   push_data  [N*W]  requester i occupies bits [i*Width +: Width]
//   push_last  [N]    final beat of the requester's current packet
//   pop_valid         downstream valid
//   pop_ready         downstream ready
//   pop_data  [W]     data of the selected requester
//   pop_last          last flag of the selected requester
//   pop_id    [Id]    index of the selected requester
//
// Modports: master = environment (drives push side and pop_ready),
//           slave  = the mux.
interface br_flow_mux_lru_pkt_if #(
  parameter int NumRequesters = 2,
  parameter int Width         = 8
);
  localparam int IdWidth = ($clog2(NumRequesters) > 1) ? $clog2(NumRequesters) : 1;

  logic [NumRequesters-1:0]       push_valid;
  logic [NumRequesters-1:0]       push_ready;
  logic [NumRequesters*Width-1:0] push_data;
  logic [NumRequesters-1:0]       push_last;
  logic                           pop_valid;
  logic                           pop_ready;
  logic [Width-1:0]               pop_data;
  logic                           pop_last;
  logic [IdWidth-1:0]             pop_id;

  modport master (
    output push_valid, push_data, push_last, pop_ready,
    input  push_ready, pop_valid, pop_data, pop_last, pop_id
  );

  modport slave (
    input  push_valid, push_data, push_last, pop_ready,
    output push_ready, pop_valid, pop_data, pop_last, pop_id
  );
endinterface

// File: rtl/br_flow_mux_lru_pkt.sv
// Packet-aware N:1 flow mux with least-recently-used arbitration.
//
// Between packets the highest-priority valid requester wins; priority is an
// LRU order that only changes when a packet completes (the finisher drops to
// lowest priority, everyone else keeps their relative order). A multi-beat
// packet locks the mux onto its requester until the last beat transfers, so
// packets are never interleaved. The datapath is purely combinational: no
// buffering, zero latency from push to pop.
//
// Ports:
//   clk     clock, all state on rising edge
//   rst     asynchronous, active-high reset
//   bus     slave side of br_flow_mux_lru_pkt_if (push/pop handshakes)
//   locked  registered, high while a packet is in progress
module br_flow_mux_lru_pkt #(
  parameter int NumRequesters = 2,
  parameter int Width         = 8,
  localparam int IdWidth      = ($clog2(NumRequesters) > 1) ? $clog2(NumRequesters) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  br_flow_mux_lru_pkt_if.slave      bus,
  output logic                      locked
);

  if (NumRequesters < 2) begin : g_bad_num_requesters
    $error("br_flow_mux_lru_pkt: NumRequesters must be at least 2");
  end
  if (Width < 1) begin : g_bad_width
    $error("br_flow_mux_lru_pkt: Width must be at least 1");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_q;
  logic [IdWidth-1:0] lock_id_q;
  logic               locked_q;

  // lru_q[0] holds the id of the highest-priority requester,
  // lru_q[NumRequesters-1] the lowest.
  logic [IdWidth-1:0] lru_q [NumRequesters];
  logic [IdWidth-1:0] lru_d [NumRequesters];

  logic               idle_found;
  logic [IdWidth-1:0] idle_id;
  logic [IdWidth-1:0] sel_id;
  logic               sel_valid;
  logic [Width-1:0]   sel_data;
  logic               sel_last;
  logic [NumRequesters-1:0] ready_c;
  logic               xfer;
  logic               done;

  // Walk the LRU order from the top; the first valid requester wins.
  always_comb begin
    idle_found = 1'b0;
    idle_id    = '0;
    for (int k = 0; k < NumRequesters; k++) begin
      if (!idle_found && bus.push_valid[lru_q[k]]) begin
        idle_found = 1'b1;
        idle_id    = lru_q[k];
      end
    end
  end

  // Once locked, only the packet owner may be selected, valid or not.
  // Gating with rst keeps the pop side silent while reset is held.
  assign sel_id    = (state_q == LOCKED) ? lock_id_q : idle_id;
  assign sel_valid = !rst && ((state_q == LOCKED) ? bus.push_valid[lock_id_q] : idle_found);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    ready_c  = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      if (sel_valid && (sel_id == IdWidth'(i))) begin
        sel_data   = bus.push_data[i*Width +: Width];
        sel_last   = bus.push_last[i];
        ready_c[i] = bus.pop_ready;
      end
    end
  end

  assign xfer = sel_valid && bus.pop_ready;
  assign done = xfer && sel_last;

  assign bus.pop_valid  = sel_valid;
  assign bus.pop_data   = sel_data;
  assign bus.pop_last   = sel_last;
  assign bus.push_ready = ready_c;
  // With nothing selected, report lock_id while locked and 0 when idle.
  assign bus.pop_id     = (state_q == LOCKED) ? lock_id_q : (sel_valid ? idle_id : '0);
  assign locked         = locked_q;

  // On packet completion the finisher is pulled out of the order, everything
  // below it shifts up one slot, and it is appended at the bottom.
  always_comb begin
    logic seen;
    seen  = 1'b0;
    lru_d = lru_q;
    if (done) begin
      for (int k = 0; k < NumRequesters - 1; k++) begin
        if (lru_q[k] == sel_id) seen = 1'b1;
        if (seen) lru_d[k] = lru_q[k+1];
      end
      lru_d[NumRequesters-1] = sel_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
      locked_q  <= 1'b0;
      for (int k = 0; k < NumRequesters; k++) begin
        lru_q[k] <= IdWidth'(k);
      end
    end else begin
      lru_q <= lru_d;
      case (state_q)
        IDLE: begin
          // A non-final beat opens a packet; single-beat packets stay idle.
          if (xfer && !sel_last) begin
            state_q   <= LOCKED;
            lock_id_q <= sel_id;
            locked_q  <= 1'b1;
          end
        end
        LOCKED: begin
          if (done) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // Upstream must hold data/last while waiting for ready.
  for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_hold_chk
    assert property (@(posedge clk) disable iff (rst)
      (bus.push_valid[gi] && $past(bus.push_valid[gi] && !bus.push_ready[gi]))
        |-> ($stable(bus.push_data[gi*Width +: Width]) && $stable(bus.push_last[gi])))
      else $error("push port %0d changed data/last while stalled", gi);
  end

endmodule

// File: tb/tb_br_flow_mux_lru_pkt.sv
module tb_br_flow_mux_lru_pkt;
  localparam int N = 4;
  localparam int W = 8;
  localparam logic [N*W-1:0] DEF_DATA = {8'h3C, 8'h2B, 8'h1A, 8'h09};

  logic clk = 1'b0;
  logic rst;
  logic locked;

  br_flow_mux_lru_pkt_if #(.NumRequesters(N), .Width(W)) bus ();

  br_flow_mux_lru_pkt #(.NumRequesters(N), .Width(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .locked (locked)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: priority list as a queue, plus lock flag/owner.
  int lru[$];
  bit m_locked;
  int m_lock;

  function automatic void model_reset();
    lru = '{0, 1, 2, 3};
    m_locked = 1'b0;
    m_lock = 0;
  endfunction

  function automatic int model_pick(input logic [N-1:0] pv, output bit v);
    int id;
    v  = 1'b0;
    id = 0;
    if (m_locked) begin
      v  = pv[m_lock];
      id = m_lock;
    end else begin
      for (int k = 0; k < lru.size(); k++) begin
        if (!v && pv[lru[k]]) begin
          v  = 1'b1;
          id = lru[k];
        end
      end
    end
    return id;
  endfunction

  function automatic void model_commit(input logic [N-1:0] pv, input logic pr, input logic [N-1:0] lv);
    bit v;
    int id;
    id = model_pick(pv, v);
    if (v && pr) begin
      if (lv[id]) begin
        m_locked = 1'b0;
        for (int k = 0; k < lru.size(); k++) begin
          if (lru[k] == id) begin
            lru.delete(k);
            break;
          end
        end
        lru.push_back(id);
      end else if (!m_locked) begin
        m_locked = 1'b1;
        m_lock = id;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.push_valid = '0;
    bus.push_last  = '1;
    bus.push_data  = DEF_DATA;
    bus.pop_ready  = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.push_valid = 4'b1111;
    bus.push_last  = '1;
    bus.push_data  = DEF_DATA;
    bus.pop_ready  = 1'b1;
    rst = 1'b1;
    #2;
    total++;
    if (bus.pop_valid !== 1'b0) begin
      bad++; $display("FAIL rst_pop_valid: got %b want 0", bus.pop_valid);
    end
    total++;
    if (bus.push_ready !== 4'b0000) begin
      bad++; $display("FAIL rst_push_ready: got %b want 0000", bus.push_ready);
    end
    step();
    total++;
    if ({locked, bus.pop_id} !== 3'b000) begin
      bad++; $display("FAIL rst_locked_id: got %b/%0d want 0/0", locked, bus.pop_id);
    end
    bus.push_valid = '0;
    step();
    rst = 1'b0;
    model_reset();
    bus.push_valid = 4'b1111;
    bus.pop_ready  = 1'b0;
    #1;
    total++;
    if ({bus.pop_valid, bus.pop_id} !== {1'b1, 2'd0}) begin
      bad++; $display("FAIL rst_first_grant: got v=%b id=%0d want v=1 id=0", bus.pop_valid, bus.pop_id);
    end
    step();
  endtask

  task automatic test_lru_order();
    do_reset();
    bus.push_valid = 4'b1010;
    bus.push_last  = 4'b1111;
    bus.pop_ready  = 1'b1;
    #1;
    total++;
    if ({bus.pop_valid, bus.pop_id, bus.push_ready, bus.pop_data} !== {1'b1, 2'd1, 4'b0010, 8'h1A}) begin
      bad++; $display("FAIL lru_grant1: got v=%b id=%0d rdy=%b d=%h want v=1 id=1 rdy=0010 d=1a",
                      bus.pop_valid, bus.pop_id, bus.push_ready, bus.pop_data);
    end
    step();
    total++;
    if ({bus.pop_valid, bus.pop_id, bus.push_ready, bus.pop_data} !== {1'b1, 2'd3, 4'b1000, 8'h3C}) begin
      bad++; $display("FAIL lru_grant2: got v=%b id=%0d rdy=%b d=%h want v=1 id=3 rdy=1000 d=3c",
                      bus.pop_valid, bus.pop_id, bus.push_ready, bus.pop_data);
    end
    step();
    total++;
    if ({bus.pop_id, bus.push_ready} !== {2'd1, 4'b0010}) begin
      bad++; $display("FAIL lru_grant3: got id=%0d rdy=%b want id=1 rdy=0010", bus.pop_id, bus.push_ready);
    end
    step();
  endtask

  task automatic test_packet_lock();
    do_reset();
    bus.push_valid = 4'b1111;
    bus.pop_ready  = 1'b1;
    for (int b = 0; b < 3; b++) begin
      bus.push_data[7:0] = 8'hA0 + 8'(b);
      bus.push_last      = (b == 2) ? 4'b1111 : 4'b1110;
      #1;
      total++;
      if ({bus.pop_id, bus.pop_data, bus.pop_last} !== {2'd0, 8'hA0 + 8'(b), (b == 2)}) begin
        bad++; $display("FAIL pkt_beat%0d: got id=%0d d=%h l=%b want id=0 d=%h l=%b",
                        b, bus.pop_id, bus.pop_data, bus.pop_last, 8'hA0 + 8'(b), (b == 2));
      end
      total++;
      if (locked !== (b != 0)) begin
        bad++; $display("FAIL pkt_locked%0d: got %b want %b", b, locked, (b != 0));
      end
      step();
    end
    total++;
    if ({locked, bus.pop_id} !== {1'b0, 2'd1}) begin
      bad++; $display("FAIL pkt_after: got locked=%b id=%0d want locked=0 id=1", locked, bus.pop_id);
    end
    step();
  endtask

  task automatic test_lock_stall();
    do_reset();
    bus.push_valid = 4'b0100;
    bus.push_last  = 4'b1011;
    bus.pop_ready  = 1'b1;
    #1;
    total++;
    if ({bus.pop_valid, bus.pop_id} !== {1'b1, 2'd2}) begin
      bad++; $display("FAIL stall_open: got v=%b id=%0d want v=1 id=2", bus.pop_valid, bus.pop_id);
    end
    step();
    bus.push_valid = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if ({bus.pop_valid, bus.push_ready, locked} !== {1'b0, 4'b0000, 1'b1}) begin
        bad++; $display("FAIL stall_c%0d: got v=%b rdy=%b locked=%b want v=0 rdy=0000 locked=1",
                        c, bus.pop_valid, bus.push_ready, locked);
      end
      total++;
      if ({bus.pop_id, bus.pop_data, bus.pop_last} !== {2'd2, 8'h00, 1'b0}) begin
        bad++; $display("FAIL stall_idle_out%0d: got id=%0d d=%h l=%b want id=2 d=00 l=0",
                        c, bus.pop_id, bus.pop_data, bus.pop_last);
      end
      step();
    end
    bus.push_valid = 4'b0100;
    bus.push_last  = 4'b1111;
    #1;
    total++;
    if ({bus.pop_valid, bus.pop_id, bus.push_ready} !== {1'b1, 2'd2, 4'b0100}) begin
      bad++; $display("FAIL stall_close: got v=%b id=%0d rdy=%b want v=1 id=2 rdy=0100",
                      bus.pop_valid, bus.pop_id, bus.push_ready);
    end
    step();
    total++;
    if (locked !== 1'b0) begin
      bad++; $display("FAIL stall_unlock: got %b want 0", locked);
    end
    bus.push_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.push_valid = 4'b0100;
    bus.push_last  = 4'b1111;
    bus.pop_ready  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if ({bus.pop_valid, bus.pop_id, bus.pop_data, bus.push_ready, locked} !==
          {1'b1, 2'd2, 8'h2B, 4'b0000, 1'b0}) begin
        bad++; $display("FAIL bp_c%0d: got v=%b id=%0d d=%h rdy=%b locked=%b want v=1 id=2 d=2b rdy=0000 locked=0",
                        c, bus.pop_valid, bus.pop_id, bus.pop_data, bus.push_ready, locked);
      end
      step();
    end
    // Priority must still be the reset order: nothing completed.
    bus.push_valid = 4'b1111;
    #1;
    total++;
    if (bus.pop_id !== 2'd0) begin
      bad++; $display("FAIL bp_order: got id=%0d want 0", bus.pop_id);
    end
    step();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    bus.push_valid = 4'b1000;
    bus.push_last  = 4'b0111;
    bus.pop_ready  = 1'b1;
    bus.push_data[31:24] = 8'hD0;
    #1;
    total++;
    if (bus.pop_id !== 2'd3) begin
      bad++; $display("FAIL rmid_beat1: got id=%0d want 3", bus.pop_id);
    end
    step();
    bus.push_data[31:24] = 8'hD1;
    #1;
    total++;
    if ({locked, bus.pop_id, bus.pop_data} !== {1'b1, 2'd3, 8'hD1}) begin
      bad++; $display("FAIL rmid_beat2: got locked=%b id=%0d d=%h want locked=1 id=3 d=d1",
                      locked, bus.pop_id, bus.pop_data);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({locked, bus.pop_valid, bus.push_ready} !== {1'b0, 1'b0, 4'b0000}) begin
      bad++; $display("FAIL rmid_async: got locked=%b v=%b rdy=%b want 0 0 0000",
                      locked, bus.pop_valid, bus.push_ready);
    end
    step();
    step();
    rst = 1'b0;
    model_reset();
    bus.push_valid = 4'b1001;
    #1;
    total++;
    if ({bus.pop_valid, bus.pop_id} !== {1'b1, 2'd0}) begin
      bad++; $display("FAIL rmid_regrant: got v=%b id=%0d want v=1 id=0", bus.pop_valid, bus.pop_id);
    end
    step();
  endtask

  task automatic test_random();
    logic [W-1:0] rd [N];
    int remain [N];
    int cnt_other [N];
    int owner;
    bit v;
    int id;
    logic [N-1:0] lv;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] got_rdy;
    logic [W-1:0] exp_d;
    logic exp_l;
    logic pr;

    do_reset();
    owner = -1;
    for (int i = 0; i < N; i++) begin
      remain[i]    = $urandom_range(1, 4);
      rd[i]        = W'($urandom);
      cnt_other[i] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        bus.push_data[i*W +: W] = rd[i];
        lv[i] = (remain[i] == 1);
      end
      bus.push_valid = 4'b1111;
      bus.push_last  = lv;
      pr = ($urandom_range(0, 3) != 0);
      bus.pop_ready  = pr;
      #1;
      id      = model_pick(4'b1111, v);
      exp_rdy = (v && pr) ? (4'b0001 << id) : 4'b0000;
      exp_d   = v ? rd[id] : '0;
      exp_l   = v ? lv[id] : 1'b0;
      total++;
      if ({bus.pop_valid, bus.pop_id, bus.pop_data, bus.pop_last, bus.push_ready} !==
          {v, 2'(id), exp_d, exp_l, exp_rdy}) begin
        bad++; $display("FAIL rnd_out c%0d: got v=%b id=%0d d=%h l=%b rdy=%b want v=%b id=%0d d=%h l=%b rdy=%b",
                        cyc, bus.pop_valid, bus.pop_id, bus.pop_data, bus.pop_last, bus.push_ready,
                        v, id, exp_d, exp_l, exp_rdy);
      end
      total++;
      if (locked !== m_locked) begin
        bad++; $display("FAIL rnd_locked c%0d: got %b want %b", cyc, locked, m_locked);
      end
      got_rdy = bus.push_ready;
      if (bus.pop_valid && bus.pop_ready) begin
        total++;
        if (owner >= 0 && int'(bus.pop_id) != owner) begin
          bad++; $display("FAIL rnd_interleave c%0d: got id=%0d want %0d", cyc, bus.pop_id, owner);
        end
        if (bus.pop_last) begin
          owner = -1;
          for (int j = 0; j < N; j++) begin
            if (j == int'(bus.pop_id)) begin
              cnt_other[j] = 0;
            end else begin
              cnt_other[j]++;
              total++;
              if (cnt_other[j] > 3) begin
                bad++; $display("FAIL rnd_fair c%0d: req %0d waited %0d packets want <=3", cyc, j, cnt_other[j]);
              end
            end
          end
        end else begin
          owner = int'(bus.pop_id);
        end
      end
      model_commit(4'b1111, pr, lv);
      step();
      for (int i = 0; i < N; i++) begin
        if (got_rdy[i]) begin
          remain[i]--;
          if (remain[i] == 0) remain[i] = $urandom_range(1, 4);
          rd[i] = W'($urandom);
        end
      end
    end
    bus.push_valid = '0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    bus.push_valid = '0;
    bus.push_last  = '0;
    bus.push_data  = '0;
    bus.pop_ready  = 1'b0;
    model_reset();
    step();
    test_reset();
    test_lru_order();
    test_packet_lock();
    test_lock_stall();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/br_flow_mux_lru_pkt.md
BR_FLOW_MUX_LRU_PKT -- requirements
Module: br_flow_mux_lru_pkt

Interface
REQ-001 SHALL have parameter NumRequesters, default 2: number of push ports; values below 2 are illegal and SHALL be rejected at elaboration.
REQ-002 SHALL have parameter Width, default 8: data width per port; values below 1 are illegal and SHALL be rejected at elaboration.
REQ-003 SHALL have derived parameter IdWidth = max(1, clog2(NumRequesters)).
REQ-004 SHALL have port clk, input, 1: single clock; all state rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port push_valid, input, NumRequesters: per-requester valid.
REQ-007 SHALL have port push_ready, output, NumRequesters: per-requester ready.
REQ-008 SHALL have port push_data, input, NumRequesters*Width: requester i occupies bits [i*Width +: Width].
REQ-009 SHALL have port push_last, input, NumRequesters: final beat of packet.
REQ-010 SHALL have port pop_valid, output, 1: downstream valid.
REQ-011 SHALL have port pop_ready, input, 1: downstream ready.
REQ-012 SHALL have port pop_data, output, Width: selected data.
REQ-013 SHALL have port pop_last, output, 1: selected last.
REQ-014 SHALL have port pop_id, output, IdWidth: index of selected requester.
REQ-015 SHALL have port locked, output, 1: high while mid-packet.

Function
REQ-016 SHALL hold two states, IDLE and LOCKED, plus lock_id register (IdWidth) and an LRU order over all requesters.
REQ-017 In IDLE, selected requester SHALL be the highest-priority (least recently completed) requester with push_valid=1; pop_valid = OR(push_valid).
REQ-018 In LOCKED, selected requester SHALL be lock_id regardless of other valids; pop_valid = push_valid[lock_id].
REQ-019 pop_data, pop_last, pop_id SHALL reflect the selected requester combinationally (zero latency, no buffering); with pop_valid=0, pop_id SHALL be 0 in IDLE and lock_id in LOCKED, and pop_data/pop_last SHALL be 0.
REQ-020 push_ready[i] SHALL equal pop_ready AND (i is selected); all non-selected push_ready SHALL be 0.
REQ-021 pop_valid SHALL NOT depend combinationally on pop_ready.
REQ-022 Transfer = pop_valid AND pop_ready; exactly one push port transfers per transfer cycle.
REQ-023 IDLE, transfer with pop_last=0: next state LOCKED, lock_id <= selected index; LRU order unchanged.
REQ-024 IDLE, transfer with pop_last=1 (single-beat packet): stay IDLE; selected requester moves to lowest priority.
REQ-025 LOCKED, transfer with pop_last=1: next state IDLE; lock_id requester moves to lowest priority.
REQ-026 LOCKED, no transfer (including push_valid[lock_id]=0): stay LOCKED; no grant to others (no timeout).
REQ-027 LRU update SHALL occur only on packet completion; relative order of all other requesters SHALL be preserved.
REQ-028 locked output SHALL be 1 exactly when state is LOCKED (registered).
REQ-029 Upstream SHALL hold push_data/push_last stable while push_valid=1 and push_ready=0; violation is a protocol error (integration assertion), not corrected.

Reset
REQ-030 On rst=1 (asynchronous assert), state SHALL become IDLE, lock_id 0, locked 0, LRU order 0 highest to NumRequesters-1 lowest.
REQ-031 Reset asserted mid-packet SHALL abandon the packet; after deassert the first grant SHALL follow the reset priority order.
REQ-032 During reset, push_ready SHALL be all 0 and pop_valid 0.

Verification (NumRequesters=4, Width=8)
REQ-033 After reset, push_valid=4'b1010, all last=1, pop_ready=1 for 2 cycles -> grant id 1 then id 3; third cycle id 1.
REQ-034 Requester 0 sends 3-beat packet (data 0xA0,0xA1,0xA2, last on 3rd) while push_valid=4'b1111 -> pop_id=0 for 3 beats, locked=1 after beat 1 until after beat 3, then id 1.
REQ-035 Locked on id 2, push_valid[2]=0 for 5 cycles while others valid -> pop_valid=0, all push_ready=0, locked stays 1.
REQ-036 pop_ready=0 with push_valid=4'b0100 for 4 cycles -> pop_valid=1, pop_id=2, pop_data stable, no state change.
REQ-037 rst asserted during beat 2 of id 3 packet -> locked=0 immediately; after release with push_valid=4'b1001 grant id 0.
REQ-038 Random all-valid traffic, 10k cycles -> no interleaving within packets; every continuously requesting requester completes a packet within 3 other packets.
